// File: rtl/eth_tx_pkg.sv
// Shared definitions for the transmit-side Ethernet/IPv4/UDP framer.
//   tx_state_t      : framer FSM states (ST_FCS only when FRAME_BUILDER_FCS_EN is defined)
//   byte constants  : preamble, SFD, IPv4 ethertype
//   length constants: header lengths, minimum frame size (DST_MAC..end of pad)
//   ip_static_sum   : 32-bit sum of the IPv4 header words that do not depend on the length
//   ip_fold/ip_cksum: one's-complement folding and final header checksum
package eth_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH,
    ST_IP,
    ST_UDP,
    ST_PAYLOAD,
    ST_PAD,
`ifdef FRAME_BUILDER_FCS_EN
    ST_FCS,
`endif
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          PREAMBLE_LEN   = 8;
  localparam int          ETH_HDR_LEN    = 14;
  localparam int          IP_HDR_LEN     = 20;
  localparam int          UDP_HDR_LEN    = 8;
  localparam int          HDR_LEN        = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int          MIN_FRAME      = 60;

  // Version/IHL/TOS, identification, flags/fragment, TTL/protocol and both
  // addresses; only total length and the checksum itself are left out.
  function automatic logic [31:0] ip_static_sum(input logic [7:0]  ttl,
                                                input logic [31:0] src_ip,
                                                input logic [31:0] dst_ip);
    ip_static_sum = 32'h0000_4500 + 32'h0000_0000 + 32'h0000_4000
                  + {16'h0000, ttl, 8'h11}
                  + {16'h0000, src_ip[31:16]} + {16'h0000, src_ip[15:0]}
                  + {16'h0000, dst_ip[31:16]} + {16'h0000, dst_ip[15:0]};
  endfunction

  function automatic logic [31:0] ip_fold(input logic [31:0] x);
    ip_fold = {16'h0000, x[15:0]} + {16'h0000, x[31:16]};
  endfunction

  // ~fold(fold(sum)); the second fold only needs its low 16 bits.
  function automatic logic [15:0] ip_cksum(input logic [31:0] sum);
    logic [31:0] f1;
    logic [15:0] f2;
    f1 = ip_fold(sum);
    f2 = f1[15:0] + f1[31:16];
    ip_cksum = ~f2;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator (reflected poly 0xEDB88320).
//   clk, rst_n : clock, synchronous active-low reset
//   init       : reload the register with 0xFFFFFFFF
//   en         : fold data into the running CRC
//   data       : byte to absorb, LSB first on the wire
//   crc        : raw register; the FCS value is ~crc
module crc32_d8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    crc_step = r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      crc <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc <= crc_step(crc, data);
    end
  end

endmodule

// File: rtl/frame_builder.sv
// Transmit framer: wraps a UDP payload byte stream into preamble/SFD,
// Ethernet, IPv4 and UDP headers, zero pad to 60 bytes and (when the macro
// FRAME_BUILDER_FCS_EN is defined) a 4-byte CRC-32 FCS sent LSB first.
//   start/payload_len : frame request, accepted only while busy==0
//   busy              : frame in progress, including the inter-frame gap
//   packet*           : payload input stream
//   tdata/tvalid/tlast/tready : registered byte-serial frame output
//   err               : one-cycle pulse on illegal length or length mismatch
// Handshakes: a byte moves when valid && ready at a rising edge. The output
// register reloads only when (!tvalid || tready), so a stalled byte holds
// tdata/tlast; packet_ready follows the same condition in ST_PAYLOAD.
module frame_builder
  import eth_tx_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd5001,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          IFG_CYCLES  = 12,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] payload_len,
  output logic        busy,
  input  logic [7:0]  packet,
  input  logic        packet_valid,
  input  logic        packet_end,
  output logic        packet_ready,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        tlast,
  input  logic        tready,
  output logic        err
);

  tx_state_t   state, nxt_state;
  logic [15:0] cnt, nxt_cnt;
  logic [15:0] len_q, total_q, cksum_q;
  logic [15:0] total_c, cksum_c, udp_len, pad_last;
  logic [7:0]  out_data, eth_byte, ip_byte, udp_byte;
  logic        out_valid, out_last, set_err, accept, load;
  logic        legal_len, last_pay, need_pad;
  logic [111:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;

  assign load      = !tvalid || tready;
  assign busy      = (state != ST_IDLE);
  assign legal_len = (payload_len != 16'd0) && (payload_len <= 16'(MAX_PAYLOAD));
  assign total_c   = 16'(IP_HDR_LEN + UDP_HDR_LEN) + payload_len;
  assign cksum_c   = ip_cksum(ip_static_sum(TTL, SRC_IP, DST_IP) + {16'h0000, total_c});
  assign udp_len   = 16'(UDP_HDR_LEN) + len_q;
  assign last_pay  = (cnt == len_q - 16'd1);
  assign need_pad  = (len_q < 16'(MIN_FRAME - HDR_LEN));
  assign pad_last  = 16'(MIN_FRAME - HDR_LEN - 1) - len_q;

  assign eth_hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4};
  assign ip_hdr  = {8'h45, 8'h00, total_q, 16'h0000, 16'h4000, TTL, 8'h11,
                    cksum_q, SRC_IP, DST_IP};
  assign udp_hdr = {SRC_PORT, DST_PORT, udp_len, 16'h0000};

  // Headers are stored MSB first; cnt walks them from the top byte down.
  assign eth_byte = eth_hdr[8*(ETH_HDR_LEN-1-int'(cnt[3:0])) +: 8];
  assign ip_byte  = ip_hdr[8*(IP_HDR_LEN-1-int'(cnt[4:0])) +: 8];
  assign udp_byte = udp_hdr[8*(UDP_HDR_LEN-1-int'(cnt[2:0])) +: 8];

`ifdef FRAME_BUILDER_FCS_EN
  logic [31:0] crc, fcs_val;
  logic [7:0]  fcs_byte;
  logic        crc_en;

  // Every byte loaded from DST_MAC through the last pad byte feeds the CRC.
  assign crc_en = load && ((state == ST_ETH) || (state == ST_IP) || (state == ST_UDP) ||
                           (state == ST_PAD) || ((state == ST_PAYLOAD) && packet_valid));
  assign fcs_val  = ~crc;
  assign fcs_byte = fcs_val[8*int'(cnt[1:0]) +: 8];

  crc32_d8 u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .init (accept),
    .en   (crc_en),
    .data (out_data),
    .crc  (crc)
  );
`endif

  // Next byte and next state; state/cnt/output register advance only on load.
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    out_data     = 8'h00;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    set_err      = 1'b0;
    accept       = 1'b0;
    packet_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (legal_len) begin
            // The first preamble byte is loaded in the accept cycle itself.
            accept    = 1'b1;
            out_data  = PREAMBLE_BYTE;
            out_valid = 1'b1;
            nxt_state = ST_PREAMBLE;
            nxt_cnt   = 16'd1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        out_valid = 1'b1;
        if (cnt == 16'(PREAMBLE_LEN - 1)) begin
          out_data  = SFD_BYTE;
          nxt_state = ST_ETH;
          nxt_cnt   = 16'd0;
        end else begin
          out_data = PREAMBLE_BYTE;
          nxt_cnt  = cnt + 16'd1;
        end
      end
      ST_ETH: begin
        out_valid = 1'b1;
        out_data  = eth_byte;
        if (cnt == 16'(ETH_HDR_LEN - 1)) begin
          nxt_state = ST_IP;
          nxt_cnt   = 16'd0;
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
      ST_IP: begin
        out_valid = 1'b1;
        out_data  = ip_byte;
        if (cnt == 16'(IP_HDR_LEN - 1)) begin
          nxt_state = ST_UDP;
          nxt_cnt   = 16'd0;
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
      ST_UDP: begin
        out_valid = 1'b1;
        out_data  = udp_byte;
        if (cnt == 16'(UDP_HDR_LEN - 1)) begin
          nxt_state = ST_PAYLOAD;
          nxt_cnt   = 16'd0;
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
      ST_PAYLOAD: begin
        packet_ready = load;
        if (packet_valid) begin
          out_valid = 1'b1;
          out_data  = packet;
          if (packet_end != last_pay) begin
            // Early end or missing end: close the frame on this byte.
            out_last  = 1'b1;
            set_err   = 1'b1;
            nxt_state = ST_IFG;
            nxt_cnt   = 16'd0;
          end else if (last_pay) begin
            nxt_cnt = 16'd0;
            if (need_pad) begin
              nxt_state = ST_PAD;
            end else begin
`ifdef FRAME_BUILDER_FCS_EN
              nxt_state = ST_FCS;
`else
              out_last  = 1'b1;
              nxt_state = ST_IFG;
`endif
            end
          end else begin
            nxt_cnt = cnt + 16'd1;
          end
        end
      end
      ST_PAD: begin
        out_valid = 1'b1;
        if (cnt == pad_last) begin
          nxt_cnt = 16'd0;
`ifdef FRAME_BUILDER_FCS_EN
          nxt_state = ST_FCS;
`else
          out_last  = 1'b1;
          nxt_state = ST_IFG;
`endif
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
`ifdef FRAME_BUILDER_FCS_EN
      ST_FCS: begin
        out_valid = 1'b1;
        out_data  = fcs_byte;
        if (cnt == 16'd3) begin
          out_last  = 1'b1;
          nxt_state = ST_IFG;
          nxt_cnt   = 16'd0;
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
`endif
      ST_IFG: begin
        // While the tlast byte is still pending the gap has not started.
        if (tvalid) begin
          nxt_cnt = 16'd0;
        end else if (cnt == 16'(IFG_CYCLES - 1)) begin
          nxt_state = ST_IDLE;
          nxt_cnt   = 16'd0;
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 16'd0;
      tdata   <= 8'h00;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
      err     <= 1'b0;
      len_q   <= 16'd0;
      total_q <= 16'd0;
      cksum_q <= 16'd0;
    end else begin
      err <= set_err && load;
      if (accept) begin
        len_q   <= payload_len;
        total_q <= total_c;
        cksum_q <= cksum_c;
      end
      if (load) begin
        state  <= nxt_state;
        cnt    <= nxt_cnt;
        tdata  <= out_data;
        tvalid <= out_valid;
        tlast  <= out_last;
      end
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Self-checking bench for frame_builder. Stimulus tasks push the expected
// frame bytes ({tlast,tdata}) into exp_q; a monitor pops and compares on
// every output handshake and checks stalled bytes stay stable.
module tb_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] payload_len = 16'd0;
  logic        busy;
  logic [7:0]  packet = 8'h00;
  logic        packet_valid = 1'b0;
  logic        packet_end = 1'b0;
  logic        packet_ready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b1;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int beats = 0;
  int err_cnt = 0;
  int last_hs_cyc = 0;
  logic [8:0] exp_q[$];
  logic [7:0] body[$];
  logic [7:0] pay[0:1499];
  logic       toggle = 1'b0;
  logic       err_prev = 1'b0;
  logic       hold_pending = 1'b0;
  logic [8:0] hold_val = 9'h000;

  // clock / reset
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  frame_builder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .payload_len (payload_len),
    .busy        (busy),
    .packet      (packet),
    .packet_valid(packet_valid),
    .packet_end  (packet_end),
    .packet_ready(packet_ready),
    .tdata       (tdata),
    .tvalid      (tvalid),
    .tlast       (tlast),
    .tready      (tready),
    .err         (err)
  );

  // downstream ready: constant 1 or 1,0,1,0...
  initial forever begin
    @(posedge clk);
    #1;
    tready = toggle ? ~tready : 1'b1;
  end

  task automatic check(input string name, input int act, input int exp_v);
    vectors = vectors + 1;
    if (act != exp_v) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // monitor / scoreboard
  initial forever begin
    int e;
    @(negedge clk);
    if (!rst_n) begin
      hold_pending = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (hold_pending) begin
        check("stall_hold", {tvalid, tlast, tdata}, {1'b1, hold_val});
        hold_pending = 1'b0;
      end
      if (tvalid && !tready) begin
        hold_val = {tlast, tdata};
        hold_pending = 1'b1;
      end
      if (tvalid && tready) begin
        e = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : -1;
        check($sformatf("beat%0d", beats), {tlast, tdata}, e);
        beats = beats + 1;
        if (tlast) last_hs_cyc = cyc;
      end
      if (err) begin
        err_cnt = err_cnt + 1;
        check("err_width", err_prev, 0);
      end
      err_prev = err;
    end
  end

  // driver tasks
  task automatic pb(input int v);
    body.push_back(v[7:0]);
  endtask

  function automatic logic [31:0] crc32_of_body();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      c = c ^ {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // end_idx == len-1 is a normal frame; smaller means packet_end arrives early.
  task automatic build_frame(input int len, input int cks, input int end_idx, output int nexp);
    int total;
    int ulen;
    logic [8:0] t;
    logic [31:0] crc;
    body.delete();
    total = 28 + len;
    ulen  = 8 + len;
    for (int i = 0; i < 6; i++) pb(8'hFF);
    pb(8'h02); pb(8'h00); pb(8'h00); pb(8'h00); pb(8'h00); pb(8'h01);
    pb(8'h08); pb(8'h00);
    pb(8'h45); pb(8'h00); pb(total >> 8); pb(total); pb(8'h00); pb(8'h00);
    pb(8'h40); pb(8'h00); pb(8'h40); pb(8'h11); pb(cks >> 8); pb(cks);
    pb(8'hC0); pb(8'hA8); pb(8'h00); pb(8'h01); pb(8'hC0); pb(8'hA8); pb(8'h00); pb(8'h02);
    pb(8'h13); pb(8'h88); pb(8'h13); pb(8'h89); pb(ulen >> 8); pb(ulen); pb(8'h00); pb(8'h00);
    for (int i = 0; i <= end_idx; i++) pb(pay[i]);
    if (end_idx == len - 1) begin
      while (body.size() < 60) pb(8'h00);
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    foreach (body[i]) exp_q.push_back({1'b0, body[i]});
    nexp = 8 + body.size();
`ifdef FRAME_BUILDER_FCS_EN
    if (end_idx == len - 1) begin
      crc = crc32_of_body();
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({1'b0, crc[7:0]});
        crc = crc >> 8;
      end
      nexp = nexp + 4;
    end
`else
    crc = 32'h0;
`endif
    t = exp_q.pop_back();
    t[8] = 1'b1;
    exp_q.push_back(t);
  endtask

  task automatic pulse_start(input int len, input bit expect_ok);
    @(negedge clk);
    start = 1'b1;
    payload_len = len[15:0];
    @(negedge clk);
    start = 1'b0;
    if (expect_ok) begin
      check("first_beat_tvalid", tvalid, 1);
      check("first_beat_data", tdata, 8'h55);
      check("busy_after_accept", busy, 1);
    end else begin
      check("illegal_err_pulse", err, 1);
      check("illegal_busy", busy, 0);
      check("illegal_tvalid", tvalid, 0);
    end
  endtask

  task automatic feed(input int n, input int end_idx);
    int i;
    int guard;
    logic rdy;
    i = 0;
    guard = 0;
    while (i < n && guard < 20000) begin
      @(negedge clk);
      packet = pay[i];
      packet_valid = 1'b1;
      packet_end = (i == end_idx);
      #1;
      rdy = packet_ready;
      @(posedge clk);
      if (rdy) i = i + 1;
      guard = guard + 1;
    end
    if (i < n) check("feed_timeout", i, n);
    @(negedge clk);
    packet_valid = 1'b0;
    packet_end = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (busy && g < 20000) begin
      @(negedge clk);
      g = g + 1;
    end
    check({name, "_busy_fall"}, busy, 0);
    check({name, "_ifg_cycles"}, cyc - last_hs_cyc - 1, 12);
  endtask

  task automatic run_frame(input string name, input int len, input int cks,
                           input int end_idx, input bit busy_poke);
    int nexp;
    int b0;
    int e0;
    build_frame(len, cks, end_idx, nexp);
    b0 = beats;
    e0 = err_cnt;
    pulse_start(len, 1'b1);
    if (busy_poke) begin
      // start while busy must be ignored without err
      @(negedge clk);
      start = 1'b1;
      payload_len = 16'd0;
      @(negedge clk);
      start = 1'b0;
    end
    feed(end_idx + 1, end_idx);
    wait_idle(name);
    check({name, "_beats"}, beats - b0, nexp);
    check({name, "_err_count"}, err_cnt - e0, (end_idx == len - 1) ? 0 : 1);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  // main sequence
  initial begin
    int e0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_packet_ready", packet_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // len=4, DE AD BE EF, tready=1, start poked while busy
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    run_frame("len4", 4, 16'hB979, 3, 1'b1);

    // len=100 with tready toggling
    for (int i = 0; i < 100; i++) pay[i] = 8'((i * 37 + 11) % 256);
    toggle = 1'b1;
    run_frame("len100_stall", 100, 16'hB919, 99, 1'b0);
    toggle = 1'b0;
    repeat (3) @(negedge clk);

    // illegal lengths
    e0 = err_cnt;
    pulse_start(0, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start(1473, 1'b0);
    repeat (20) @(negedge clk);
    check("illegal_err_count", err_cnt - e0, 2);
    check("illegal_busy_after", busy, 0);

    // early packet_end on the 2nd of 4 bytes
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    run_frame("early_end", 4, 16'hB979, 1, 1'b0);

    // reset in the middle of the payload
    begin
      int nexp;
      build_frame(4, 16'hB979, 3, nexp);
      pulse_start(4, 1'b1);
      feed(2, 3);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #1;
      check("midrst_tvalid", tvalid, 0);
      check("midrst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    run_frame("after_rst", 4, 16'hB979, 3, 1'b0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
